// File: rtl/fp_to_tc_pkg.sv
// Shared format widths and FSM state encoding for the FPCVT triple decoder.
package fp_to_tc_pkg;

  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int INT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_to_tc.sv
// Decodes a (sign, exponent, significand) triple into a 12-bit two's-complement
// integer using a one-bit-per-cycle left shifter, with valid/ready on both sides.
module fp_to_tc
  import fp_to_tc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [SIG_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out
);

  state_t             state_reg, state_next;
  logic               sgn_reg, sgn_next;
  logic [EXP_W-1:0]   cnt_reg, cnt_next;
  logic [INT_W-1:0]   acc_reg, acc_next;
  logic [INT_W-1:0]   out_reg, out_next;
  logic               out_valid_reg, out_valid_next;

  // Accept is only possible in IDLE; decoded straight from the state register.
  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign out       = out_reg;

  // State and datapath registers; reset discards any in-flight conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      sgn_reg       <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sgn_reg       <= sgn_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Next-state logic: latch on accept, shift E times, negate if needed, hold until taken.
  always_comb begin
    state_next     = state_reg;
    sgn_next       = sgn_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          sgn_next   = S;
          cnt_next   = E;
          acc_next   = {{(INT_W-SIG_W){1'b0}}, F};
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg != '0) begin
          acc_next = acc_reg << 1;
          cnt_next = cnt_reg - 1'b1;
        end else begin
          // Magnitude never exceeds 1920, so the 12-bit negation cannot overflow.
          out_next       = sgn_reg ? (~acc_reg + 1'b1) : acc_reg;
          out_valid_next = 1'b1;
          state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_to_tc.sv
// Scoreboard bench for fp_to_tc: expected values queued on accept, checked on output handshake.
module tb_fp_to_tc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];

  fp_to_tc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [11:0] model(input bit s, input int e, input int f);
    int v;
    logic [11:0] r;
    v = f * (1 << e);
    if (s) v = -v;
    r = v[11:0];
    return r;
  endfunction

  // Present a triple at a negedge and let it be accepted on the next posedge.
  task automatic do_accept(input bit s, input int e, input int f);
    int waitc;
    @(negedge clk);
    S = s; E = e[2:0]; F = f[3:0];
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    @(posedge clk);
    exp_q.push_back(model(s, e, f));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall, then complete the output handshake.
  // Called at the first negedge after the accept edge.
  task automatic do_finish(input int e, input int stall, input bit hold_req);
    int lat;
    logic [11:0] expv;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, e + 1);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 0, 1);
      return;
    end
    expv = exp_q[0];
    if (!out_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    if (hold_req) begin
      S = 1'b1; E = 3'd3; F = 4'd9;
      in_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out", int'(out), int'(expv));
      check("stall_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("out", int'(out), int'(exp_q.pop_front()));
    $display("xfer S=%0d E=%0d F=%0d out=0x%03h lat=%0d stall=%0d", dut.sgn_reg, e, 0, out, lat, stall);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", int'(out_valid), 0);
    check("post_in_ready", int'(in_ready), 1);
    check("post_out_hold", int'(out), int'(expv));
  endtask

  task automatic convert(input bit s, input int e, input int f, input int stall);
    do_accept(s, e, f);
    do_finish(e, stall, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S = 1'b0; E = '0; F = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out", int'(out), 0);
    rst = 1'b0;

    convert(1'b0, 0, 11, 0);
    convert(1'b0, 2, 11, 0);
    convert(1'b0, 2, 12, 0);
    convert(1'b1, 7, 15, 0);
    convert(1'b1, 5, 0, 0);

    // Backpressure with a pending request that must not be taken.
    do_accept(1'b0, 3, 7);
    do_finish(3, 5, 1'b1);

    // Reset in the middle of a long shift.
    do_accept(1'b1, 7, 13);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out", int'(out), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    convert(1'b0, 1, 1, 0);

    // Exhaustive sweep with random output stalls.
    for (int k = 0; k < 256; k++) begin
      convert(k[7], int'(k[6:4]), int'(k[3:0]), int'($urandom_range(0, 3)));
    end

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
